// File: rtl/branch_defs.sv
// rtl/branch_defs.sv - shared constants and types for the branch/jump control FSM
// Purpose: opcode/funct constants, state and sequence-class encodings, and the
//          control-field codes driven by branch_ctrl_fsm.
// Ports:   none (package).
package branch_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLE   = 6'h06;
  localparam logic [5:0] OP_BGT   = 6'h07;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMP  = 3'd1,
    S_BR   = 3'd2,
    S_LINK = 3'd3,
    S_JUMP = 3'd4,
    S_JR   = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    SEQ_BRANCH  = 3'd0,
    SEQ_J       = 3'd1,
    SEQ_JAL     = 3'd2,
    SEQ_JR      = 3'd3,
    SEQ_ILLEGAL = 3'd4
  } seq_t;

  // Condition-select bits captured at hand-off and replayed in BR.
  typedef struct packed {
    logic cmp_kind;
    logic eq_or_ne;
    logic gt_or_lt;
  } cond_t;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [2:0] ALUOP_IDLE = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b010;

  localparam logic [1:0] ALUSRCB_RT  = 2'b00;
  localparam logic [1:0] REGDST_RA   = 2'b10;
  localparam logic [1:0] MEMTOREG_PC = 2'b10;

endpackage

// File: rtl/branch_decode.sv
// rtl/branch_decode.sv - opcode/funct to sequence-class and condition-select decoder
// Purpose: purely combinational classification of a branch/jump instruction.
// Ports:   opcode, funct (in, 6 each); seq (out, sequence class);
//          cond (out, CmpKind/EQorNE/GTorLT for branches, zero otherwise).
module branch_decode
  import branch_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output seq_t       seq,
  output cond_t      cond
);

  always_comb begin
    seq  = SEQ_ILLEGAL;
    cond = '0;
    case (opcode)
      OP_BEQ: seq = SEQ_BRANCH;
      OP_BNE: begin
        seq           = SEQ_BRANCH;
        cond.eq_or_ne = 1'b1;
      end
      OP_BGT: begin
        seq           = SEQ_BRANCH;
        cond.cmp_kind = 1'b1;
      end
      // ble is "not greater": same Gt path, inverted.
      OP_BLE: begin
        seq           = SEQ_BRANCH;
        cond.cmp_kind = 1'b1;
        cond.gt_or_lt = 1'b1;
      end
      OP_J:     seq = SEQ_J;
      OP_JAL:   seq = SEQ_JAL;
      OP_RTYPE: if (funct == FUNCT_JR) seq = SEQ_JR;
      default:  seq = SEQ_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/branch_ctrl_fsm.sv
// rtl/branch_ctrl_fsm.sv - multicycle PC-update sequencer for branch and jump instructions
// Purpose: after the main FSM hands off with start, steps through CMP/BR, LINK/JUMP,
//          JUMP, JR or ERR and emits Moore PC-write, ALU and writeback controls.
// Ports:   clk, reset_n (async active-low), start, opcode[5:0], funct[5:0] in;
//          busy, done, illegal, PCWrite, PCWriteCond, EQorNE, GTorLT, CmpKind,
//          PCSource[1:0], ALUSrcA, ALUSrcB[1:0], ALUOp[2:0], RegWrite,
//          RegDst[1:0], MemtoReg[1:0] out.
module branch_ctrl_fsm
  import branch_defs::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       EQorNE,
  output logic       GTorLT,
  output logic       CmpKind,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg
);

  state_t state, state_next;
  seq_t   dec_seq;
  cond_t  dec_cond, cond_q;
  // Low for the first edge after reset release so a start coincident with
  // release can never launch a sequence, whatever the edge ordering.
  logic   armed;
  logic   accept;

  branch_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .seq    (dec_seq),
    .cond   (dec_cond)
  );

  assign accept = (state == S_IDLE) && start && armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cond_q <= '0;
      armed  <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
      if (accept) cond_q <= dec_cond;
    end
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b1;
    done        = 1'b0;
    illegal     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    EQorNE      = 1'b0;
    GTorLT      = 1'b0;
    CmpKind     = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcA     = 1'b0;
    ALUSrcB     = ALUSRCB_RT;
    ALUOp       = ALUOP_IDLE;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) begin
          case (dec_seq)
            SEQ_BRANCH: state_next = S_CMP;
            SEQ_J:      state_next = S_JUMP;
            SEQ_JAL:    state_next = S_LINK;
            SEQ_JR:     state_next = S_JR;
            default:    state_next = S_ERR;
          endcase
        end
      end
      S_CMP: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = ALUSRCB_RT;
        ALUOp      = ALUOP_SUB;
        state_next = S_BR;
      end
      // ALU still subtracting rs-rt so Zero/Gt are valid for the selector.
      S_BR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = ALUSRCB_RT;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        CmpKind     = cond_q.cmp_kind;
        EQorNE      = cond_q.eq_or_ne;
        GTorLT      = cond_q.gt_or_lt;
        done        = 1'b1;
        state_next  = S_IDLE;
      end
      // PC already holds PC+4 from fetch, so it is the link value.
      S_LINK: begin
        RegWrite   = 1'b1;
        RegDst     = REGDST_RA;
        MemtoReg   = MEMTOREG_PC;
        state_next = S_JUMP;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_JR: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_REGA;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_ERR: begin
        illegal    = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_branch_ctrl_fsm.sv
// tb/tb_branch_ctrl_fsm.sv - directed self-checking bench for branch_ctrl_fsm
module tb_branch_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       busy, done, illegal, PCWrite, PCWriteCond, EQorNE, GTorLT, CmpKind;
  logic [1:0] PCSource;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;

  always #5 clk = ~clk;

  branch_ctrl_fsm dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .opcode      (opcode),
    .funct       (funct),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .EQorNE      (EQorNE),
    .GTorLT      (GTorLT),
    .CmpKind     (CmpKind),
    .PCSource    (PCSource),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg)
  );

  // {busy,done,illegal}, {PCWrite,PCWriteCond}, {EQorNE,GTorLT,CmpKind},
  // PCSource, ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst, MemtoReg
  logic [20:0] ctl;
  assign ctl = {busy, done, illegal, PCWrite, PCWriteCond, EQorNE, GTorLT, CmpKind,
                PCSource, ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst, MemtoReg};

  localparam logic [20:0] E_IDLE = 21'd0;
  localparam logic [20:0] E_CMP  = {3'b100, 2'b00, 3'b000, 2'b00, 1'b1, 2'b00, 3'b010, 1'b0, 2'b00, 2'b00};
  localparam logic [20:0] E_BEQ  = {3'b110, 2'b01, 3'b000, 2'b01, 1'b1, 2'b00, 3'b010, 1'b0, 2'b00, 2'b00};
  localparam logic [20:0] E_BNE  = {3'b110, 2'b01, 3'b100, 2'b01, 1'b1, 2'b00, 3'b010, 1'b0, 2'b00, 2'b00};
  localparam logic [20:0] E_BGT  = {3'b110, 2'b01, 3'b001, 2'b01, 1'b1, 2'b00, 3'b010, 1'b0, 2'b00, 2'b00};
  localparam logic [20:0] E_BLE  = {3'b110, 2'b01, 3'b011, 2'b01, 1'b1, 2'b00, 3'b010, 1'b0, 2'b00, 2'b00};
  localparam logic [20:0] E_LINK = {3'b100, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b1, 2'b10, 2'b10};
  localparam logic [20:0] E_JUMP = {3'b110, 2'b10, 3'b000, 2'b10, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00};
  localparam logic [20:0] E_JR   = {3'b110, 2'b10, 3'b000, 2'b11, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00};
  localparam logic [20:0] E_ERR  = {3'b111, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00};

  int vectors = 0;
  int miscompares = 0;
  int done_count = 0;

  // Datapath model around the FSM: PC, $31, rs/rt values and targets.
  logic [31:0] pc, r31, reg_a, reg_b, br_target, j_target, snap;
  int          d0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [20:0] exp);
    check(tag, {11'd0, ctl}, {11'd0, exp});
  endtask

  // Apply the current cycle's controls to the model, then advance one clock.
  task automatic tick();
    logic zero, gt, taken;
    check("pcw_exclusive", {31'd0, PCWrite & PCWriteCond}, 32'd0);
    zero  = ((reg_a - reg_b) == 32'd0);
    gt    = ($signed(reg_a) > $signed(reg_b));
    taken = PCWrite | (PCWriteCond & (CmpKind ? (gt ^ GTorLT) : (zero ^ EQorNE)));
    if (done) done_count++;
    if (RegWrite && RegDst == 2'b10 && MemtoReg == 2'b10) r31 = pc;
    if (taken) begin
      case (PCSource)
        2'b01:   pc = br_target;
        2'b10:   pc = j_target;
        2'b11:   pc = reg_a;
        default: pc = reg_a - reg_b;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_branch(input string tag, input logic [5:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [20:0] exp_br,
                            input logic [31:0] exp_pc);
    reg_a = a; reg_b = b; pc = 32'h100; br_target = 32'h200;
    opcode = op; funct = 6'h00; start = 1'b1;
    tick();
    start = 1'b0;
    check_ctl({tag, "_cmp"}, E_CMP);
    tick();
    check_ctl({tag, "_br"}, exp_br);
    tick();
    check_ctl({tag, "_idle"}, E_IDLE);
    check({tag, "_pc"}, pc, exp_pc);
  endtask

  initial begin
    start = 1'b0; opcode = 6'h00; funct = 6'h00;
    pc = 32'h100; r31 = 32'h0; reg_a = 32'h0; reg_b = 32'h0;
    br_target = 32'h200; j_target = 32'h4000;

    #1 reset_n = 1'b0;
    #1 check_ctl("reset_state", E_IDLE);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    tick(); tick();
    check_ctl("idle_after_reset", E_IDLE);

    run_branch("beq_eq", 6'h04, 32'd5, 32'd5, E_BEQ, 32'h200);
    run_branch("beq_ne", 6'h04, 32'd5, 32'd6, E_BEQ, 32'h100);
    run_branch("bne_ne", 6'h05, 32'd5, 32'd6, E_BNE, 32'h200);
    run_branch("bgt_7_3", 6'h07, 32'd7, 32'd3, E_BGT, 32'h200);
    run_branch("ble_7_3", 6'h06, 32'd7, 32'd3, E_BLE, 32'h100);
    run_branch("ble_3_3", 6'h06, 32'd3, 32'd3, E_BLE, 32'h200);

    // jal: link then jump; $31 takes the PC+4 already in PC
    pc = 32'h104; r31 = 32'h0; j_target = 32'h4000;
    opcode = 6'h03; start = 1'b1;
    tick(); start = 1'b0;
    check_ctl("jal_link", E_LINK);
    tick();
    check_ctl("jal_jump", E_JUMP);
    tick();
    check_ctl("jal_idle", E_IDLE);
    check("jal_r31", r31, 32'h104);
    check("jal_pc", pc, 32'h4000);

    // jr
    reg_a = 32'h888; opcode = 6'h00; funct = 6'h08; start = 1'b1;
    tick(); start = 1'b0;
    check_ctl("jr_state", E_JR);
    tick();
    check_ctl("jr_idle", E_IDLE);
    check("jr_pc", pc, 32'h888);

    // R-type with a non-jr funct is unsupported
    funct = 6'h20; start = 1'b1;
    tick(); start = 1'b0;
    check_ctl("rtype_add_err", E_ERR);
    tick();

    // opcode 0x3F: illegal, nothing written
    snap = pc; opcode = 6'h3F; funct = 6'h00; start = 1'b1;
    tick(); start = 1'b0;
    check_ctl("op3f_err", E_ERR);
    tick();
    check_ctl("op3f_idle", E_IDLE);
    check("op3f_pc", pc, snap);
    check("op3f_r31", r31, 32'h104);

    // start held through CMP is ignored: exactly one done
    d0 = done_count;
    reg_a = 32'd5; reg_b = 32'd5; opcode = 6'h04; start = 1'b1;
    tick();
    check_ctl("busy_cmp", E_CMP);
    tick();
    check_ctl("busy_br", E_BEQ);
    start = 1'b0;
    tick();
    check_ctl("busy_idle", E_IDLE);
    tick();
    check_ctl("busy_still_idle", E_IDLE);
    check("busy_one_done", done_count - d0, 32'd1);

    // back-to-back: start in the cycle after done begins a new sequence
    j_target = 32'h5000; opcode = 6'h02; start = 1'b1;
    tick();
    check_ctl("b2b_jump", E_JUMP);
    tick();
    check_ctl("b2b_idle", E_IDLE);
    opcode = 6'h3F;
    tick(); start = 1'b0;
    check_ctl("b2b_err", E_ERR);
    tick();
    check("b2b_pc", pc, 32'h5000);

    // reset mid-LINK: outputs clear without a clock, no JUMP afterwards
    pc = 32'h104; r31 = 32'h0; j_target = 32'h6000;
    opcode = 6'h03; start = 1'b1;
    tick(); start = 1'b0;
    check_ctl("rst_link", E_LINK);
    #2 reset_n = 1'b0;
    #1 check_ctl("rst_async_outputs", E_IDLE);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    check_ctl("rst_release_idle", E_IDLE);
    tick();
    check_ctl("rst_no_jump", E_IDLE);
    check("rst_pc", pc, 32'h104);
    check("rst_r31", r31, 32'h0);

    // start coincident with reset release is ignored
    reset_n = 1'b0;
    opcode = 6'h02; start = 1'b1;
    @(posedge clk);
    reset_n = 1'b1;
    #1 start = 1'b0;
    check_ctl("coinc_idle", E_IDLE);
    tick();
    check_ctl("coinc_still_idle", E_IDLE);
    tick();
    check("coinc_pc", pc, 32'h104);

    // normal operation resumes
    opcode = 6'h02; start = 1'b1;
    tick(); start = 1'b0;
    check_ctl("resume_jump", E_JUMP);
    tick();
    check("resume_pc", pc, 32'h6000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
